pc_trace_buffer: RTL and testbench
==================================

# pc_trace_buffer

Synthesizable commit-trace capture unit that sits beside `sccomp_dataflow` and consumes its `pc`/`inst` outputs. It detects each PC change, records the retiring instruction's offset and encoding with a sequence number in an on-chip FIFO, and drains the records through a valid/ready port to a host or UART bridge. It is the hardware counterpart of the bench-side per-PC-change trace dump, so post-synthesis runs can be compared against the simulation trace.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of 2, minimum 2.
- `PC_BASE`, 32'h00400000: text-segment base; it is subtracted from the reported PC.

Ports:
- `clk_in` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous assertion, active-low.
- `pc` input 32: current PC from the CPU.
- `inst` input 32: instruction at `pc`.
- `trace_en` input 1: capture enable.
- `out_valid` output 1: a record is presented.
- `out_ready` input 1: consumer accepts the record.
- `out_pc_off` output 32: recorded PC minus `PC_BASE`.
- `out_inst` output 32: recorded instruction.
- `out_seq` output 16: record sequence number.
- `overflow` output 1: sticky flag; at least one record was dropped.
- `level` output log2(DEPTH)+1: FIFO occupancy.
- `drop_cnt` output 16: dropped-record count (see Configuration).

## Operation
- Tracker registers:
  - `fpc` resets to `PC_BASE`.
  - `finst` resets to 0.
  - `seq` resets to 0.
- Commit event: `trace_en`=1 and `pc != fpc` at a rising edge.
- On a commit event:
  - Form the record {`fpc - PC_BASE` (mod 2^32), `finst`, `seq`}. The record describes the instruction that just retired, not the new PC.
  - Load `fpc<=pc` and `finst<=inst`.
  - Increment `seq`; it wraps from 16'hFFFF to 0.
- When `trace_en`=0, `fpc`/`finst` still track `pc`/`inst`, but no record is formed and `seq` holds. Re-enabling therefore does not emit a stale record.
- FIFO: circular buffer with read and write pointers one bit wider than the index, so full and empty are distinguishable.
- Push when full with no pop in the same cycle:
  - The record is dropped.
  - `overflow` sets and stays set until reset.
  - `seq` still increments, so the consumer sees a gap.
- Push and pop in the same cycle when full: both succeed and `level` is unchanged.
- Push and pop in the same cycle when empty: the push is stored and `out_valid` rises next cycle. There is no combinational bypass.
- Output side is first-word-fall-through from registered storage. `out_*` always show the head entry while `out_valid`=1.
- Pop happens when `out_valid && out_ready`.
- `out_pc_off`, `out_inst` and `out_seq` must hold stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: `out_valid`=0, `out_pc_off`=0, `out_inst`=0, `out_seq`=0, `overflow`=0, `level`=0, `drop_cnt`=0. Both FIFO pointers are 0.
- Capture latency: a commit event at edge N gives `out_valid`=1 after edge N when the FIFO was empty.
- Throughput: one push and one pop per cycle are sustained.
- `level` updates at the same edge as the push or pop that changes it.
- Reset asserted mid-operation: all contents are discarded immediately and outputs return to their reset values asynchronously. After deassertion, the first PC change reports offset 0 (`fpc`=`PC_BASE`).
- A single-cycle PC hold or repeat (`pc == fpc`) generates no record. Consecutive identical PCs are never recorded twice.

## Configuration
- Macro `PC_TRACE_DROPCNT_EN`.
- Defined:
  - `drop_cnt` is a 16-bit counter that increments on each dropped record.
  - It saturates at 16'hFFFF.
  - It clears only on reset.
- Undefined:
  - No counter logic is built and `drop_cnt` is tied to 0.
  - `overflow` and the `seq` gap remain the only loss indicators.

## Test plan
- Reset then PC sequence 0x00400000 → 0x00400004 (inst 0x20010001) → 0x00400008, `out_ready`=1 → first record {off 0, inst 0, seq 0}, second record {off 4, inst 0x20010001, seq 1}.
- `out_ready`=0 with 20 PC changes, DEPTH=16 → `level`=16, `overflow`=1, `drop_cnt`=4 (macro defined) or 0 (macro undefined). Then drain with `out_ready`=1 → seq 0..15 in order, and the next record after refill shows seq 20.
- Hold `out_ready`=0 for 5 cycles with 1 entry → `out_*` stable and `out_valid` held. Pulse `out_ready` → `level` drops to 0 and `out_valid`=0 next cycle.
- Full FIFO with a simultaneous commit event and pop → `level` stays 16, `overflow` unchanged, and the new record appears at the tail.
- `trace_en`=0 while PC moves 0x00400000 → 0x00400010, then `trace_en`=1 and PC → 0x00400014 → exactly one record {off 0x10, seq 0}.
- Assert `reset_n` low asynchronously, between edges, with 3 entries queued → `out_valid`=0 and `level`=0 immediately. After release, first record off=0, seq 0.

Source files
------------

// File: rtl/pc_trace_buffer_if.sv
// Record drain port of pc_trace_buffer: valid/ready handshake plus record fields.
// The producer uses the master modport and the host or UART bridge uses the slave modport.
interface pc_trace_buffer_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc_off;
   logic [31:0] out_inst;
   logic [15:0] out_seq;

   modport master (
      output out_valid,
      output out_pc_off,
      output out_inst,
      output out_seq,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_pc_off,
      input  out_inst,
      input  out_seq,
      output out_ready
   );
endinterface

// File: rtl/pc_trace_buffer.sv
// Commit-trace capture: records {pc offset, inst, seq} on every PC change into a FIFO drained by valid/ready.
// Optional saturating dropped-record counter is built when PC_TRACE_DROPCNT_EN is defined.
module pc_trace_buffer #(
   parameter int unsigned DEPTH   = 16,
   parameter logic [31:0] PC_BASE = 32'h0040_0000
) (
   input  logic                     clk_in,
   input  logic                     reset_n,
   input  logic [31:0]              pc,
   input  logic [31:0]              inst,
   input  logic                     trace_en,
   pc_trace_buffer_if.master        trace,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [31:0] fpc_r;
   logic [31:0] finst_r;
   logic [15:0] seq_r;
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic [79:0] mem_r [DEPTH];
   logic        overflow_r;

   logic        commit_s;
   logic        track_load_s;
   logic        empty_s;
   logic        full_s;
   logic        pop_s;
   logic        push_s;
   logic        drop_s;
   logic [79:0] rec_s;
   logic [79:0] head_s;

   // Commit detection, FIFO status and push/pop/drop decisions
   always_comb begin
      commit_s     = trace_en && (pc != fpc_r);
      track_load_s = !trace_en || commit_s;
      empty_s      = (wr_ptr_r == rd_ptr_r);
      full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      pop_s        = !empty_s && trace.out_ready;
      push_s       = commit_s && (!full_s || pop_s);
      drop_s       = commit_s && full_s && !pop_s;
      rec_s        = {fpc_r - PC_BASE, finst_r, seq_r};
      head_s       = mem_r[rd_ptr_r[AW-1:0]];
   end

   // Tracker of the retiring instruction and the record sequence number
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         fpc_r   <= PC_BASE;
         finst_r <= 32'd0;
         seq_r   <= 16'd0;
      end else begin
         if (track_load_s) begin
            fpc_r   <= pc;
            finst_r <= inst;
         end
         if (commit_s) begin
            seq_r <= seq_r + 16'd1;
         end
      end
   end

   // FIFO pointers; the extra MSB separates full from empty
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Record storage, cleared so the idle head reads as zero
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 80'd0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= rec_s;
      end
   end

   // Sticky loss flag
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end
   end

`ifdef PC_TRACE_DROPCNT_EN
   logic [15:0] drop_cnt_r;

   // Saturating dropped-record counter
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt_r <= 16'd0;
      end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'd1;
      end
   end

   assign drop_cnt = drop_cnt_r;
`else
   assign drop_cnt = 16'd0;
`endif

   assign overflow         = overflow_r;
   assign level            = wr_ptr_r - rd_ptr_r;
   assign trace.out_valid  = !empty_s;
   assign trace.out_pc_off = head_s[79:48];
   assign trace.out_inst   = head_s[47:16];
   assign trace.out_seq    = head_s[15:0];

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Self-checking bench for pc_trace_buffer: directed scenarios plus random traffic against a queue-based model.
// Expected drop_cnt follows PC_TRACE_DROPCNT_EN as defined for the build.
module tb_pc_trace_buffer;

   localparam int          DEPTH   = 16;
   localparam logic [31:0] PC_BASE = 32'h0040_0000;

   logic        clk_in = 1'b0;
   logic        reset_n;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        trace_en;
   logic        overflow;
   logic [4:0]  level;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk_in = ~clk_in;

   pc_trace_buffer_if tif ();

   pc_trace_buffer #(.DEPTH(DEPTH), .PC_BASE(PC_BASE)) dut (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .pc       (pc),
      .inst     (inst),
      .trace_en (trace_en),
      .trace    (tif),
      .overflow (overflow),
      .level    (level),
      .drop_cnt (drop_cnt)
   );

   typedef struct {
      logic [31:0] off;
      logic [31:0] ins;
      logic [15:0] seq;
   } rec_t;

   rec_t        q[$];
   logic [31:0] m_fpc;
   logic [31:0] m_finst;
   logic [15:0] m_seq;
   logic        m_ovf;
   int          m_drops;
   logic [31:0] cur_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_fpc   = PC_BASE;
      m_finst = 32'd0;
      m_seq   = 16'd0;
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   // Called right after a rising edge with the inputs that edge sampled.
   task automatic model_edge();
      bit   do_commit;
      rec_t r;
      do_commit = trace_en && (pc != m_fpc);
      if (q.size() != 0 && tif.out_ready) void'(q.pop_front());
      if (do_commit) begin
         r.off = m_fpc - PC_BASE;
         r.ins = m_finst;
         r.seq = m_seq;
         if (q.size() < DEPTH) q.push_back(r);
         else begin
            m_ovf = 1'b1;
            m_drops++;
         end
         m_seq = m_seq + 16'd1;
      end
      if (!trace_en || do_commit) begin
         m_fpc   = pc;
         m_finst = inst;
      end
   endtask

   function automatic logic [31:0] exp_drops();
`ifdef PC_TRACE_DROPCNT_EN
      return (m_drops > 65535) ? 32'd65535 : 32'(m_drops);
`else
      return 32'd0;
`endif
   endfunction

   task automatic check_model();
      chk("valid", {31'd0, tif.out_valid}, {31'd0, q.size() != 0});
      chk("level", {27'd0, level}, 32'(q.size()));
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("drop_cnt", {16'd0, drop_cnt}, exp_drops());
      if (q.size() != 0) begin
         chk("pc_off", tif.out_pc_off, q[0].off);
         chk("inst", tif.out_inst, q[0].ins);
         chk("seq", {16'd0, tif.out_seq}, {16'd0, q[0].seq});
      end
   endtask

   task automatic step(input logic [31:0] p, input logic [31:0] i, input logic en, input logic rdy);
      pc            = p;
      inst          = i;
      trace_en      = en;
      tif.out_ready = rdy;
      @(posedge clk_in);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic apply_reset();
      reset_n       = 1'b0;
      pc            = PC_BASE;
      inst          = 32'd0;
      trace_en      = 1'b0;
      tif.out_ready = 1'b0;
      model_reset();
      cur_pc = PC_BASE;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset values
      apply_reset();
      chk("rst_valid", {31'd0, tif.out_valid}, 32'd0);
      chk("rst_level", {27'd0, level}, 32'd0);
      chk("rst_pc_off", tif.out_pc_off, 32'd0);
      chk("rst_inst", tif.out_inst, 32'd0);
      chk("rst_seq", {16'd0, tif.out_seq}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_drop", {16'd0, drop_cnt}, 32'd0);

      // Basic capture: record describes the retiring instruction
      step(PC_BASE, 32'd0, 1'b1, 1'b1);
      chk("hold_no_rec", {27'd0, level}, 32'd0);
      step(PC_BASE + 32'd4, 32'h2001_0001, 1'b1, 1'b1);
      chk("r0_valid", {31'd0, tif.out_valid}, 32'd1);
      chk("r0_off", tif.out_pc_off, 32'd0);
      chk("r0_inst", tif.out_inst, 32'd0);
      chk("r0_seq", {16'd0, tif.out_seq}, 32'd0);
      step(PC_BASE + 32'd8, 32'h2002_0002, 1'b1, 1'b1);
      chk("r1_off", tif.out_pc_off, 32'd4);
      chk("r1_inst", tif.out_inst, 32'h2001_0001);
      chk("r1_seq", {16'd0, tif.out_seq}, 32'd1);
      step(PC_BASE + 32'd8, 32'h2002_0002, 1'b1, 1'b1);

      // Overflow: 20 commits into 16 entries
      apply_reset();
      for (int k = 1; k <= 20; k++) begin
         cur_pc = PC_BASE + 32'(4 * k);
         step(cur_pc, 32'(k), 1'b1, 1'b0);
      end
      chk("ovf_level", {27'd0, level}, 32'd16);
      chk("ovf_flag", {31'd0, overflow}, 32'd1);
`ifdef PC_TRACE_DROPCNT_EN
      chk("ovf_drops", {16'd0, drop_cnt}, 32'd4);
`else
      chk("ovf_drops", {16'd0, drop_cnt}, 32'd0);
`endif
      for (int k = 0; k < 16; k++) begin
         chk("drain_seq", {16'd0, tif.out_seq}, 32'(k));
         step(cur_pc, 32'd20, 1'b1, 1'b1);
      end
      chk("drained", {27'd0, level}, 32'd0);
      cur_pc = cur_pc + 32'd4;
      step(cur_pc, 32'd21, 1'b1, 1'b0);
      chk("gap_seq", {16'd0, tif.out_seq}, 32'd20);

      // Full FIFO with simultaneous push and pop
      for (int k = 0; k < 15; k++) begin
         cur_pc = cur_pc + 32'd4;
         step(cur_pc, 32'(100 + k), 1'b1, 1'b0);
      end
      chk("refull", {27'd0, level}, 32'd16);
      cur_pc = cur_pc + 32'd4;
      step(cur_pc, 32'd200, 1'b1, 1'b1);
      chk("pp_level", {27'd0, level}, 32'd16);
      chk("pp_ovf", {31'd0, overflow}, 32'd1);
      for (int k = 0; k < 16; k++) begin
         chk("tail_seq", {16'd0, tif.out_seq}, 32'(21 + k));
         step(cur_pc, 32'd200, 1'b1, 1'b1);
      end

      // trace_en=0 tracking, then a single stall-held record
      apply_reset();
      for (int k = 1; k <= 4; k++) begin
         step(PC_BASE + 32'(4 * k), 32'h0000_1230 + 32'(k), 1'b0, 1'b0);
      end
      chk("dis_level", {27'd0, level}, 32'd0);
      step(PC_BASE + 32'h14, 32'h0000_5555, 1'b1, 1'b0);
      chk("en_level", {27'd0, level}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         step(PC_BASE + 32'h14, 32'h0000_5555, 1'b1, 1'b0);
         chk("stall_valid", {31'd0, tif.out_valid}, 32'd1);
         chk("stall_off", tif.out_pc_off, 32'h10);
         chk("stall_inst", tif.out_inst, 32'h0000_1234);
         chk("stall_seq", {16'd0, tif.out_seq}, 32'd0);
      end
      step(PC_BASE + 32'h14, 32'h0000_5555, 1'b1, 1'b1);
      chk("pulse_level", {27'd0, level}, 32'd0);
      chk("pulse_valid", {31'd0, tif.out_valid}, 32'd0);

      // Asynchronous reset with 3 entries queued
      for (int k = 1; k <= 3; k++) begin
         step(PC_BASE + 32'h14 + 32'(4 * k), 32'(k), 1'b1, 1'b0);
      end
      chk("pre_rst_level", {27'd0, level}, 32'd3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, tif.out_valid}, 32'd0);
      chk("arst_level", {27'd0, level}, 32'd0);
      apply_reset();
      step(PC_BASE + 32'h40, 32'h0000_0077, 1'b1, 1'b0);
      chk("post_rst_off", tif.out_pc_off, 32'd0);
      chk("post_rst_seq", {16'd0, tif.out_seq}, 32'd0);

      // Random traffic against the model
      apply_reset();
      for (int k = 0; k < 600; k++) begin
         step(PC_BASE + 32'(4 * $urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3) != 0,
              (k < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
